// File: rtl/ex_id_bypass_unit_pkg.sv
// Shared widths and the pipeline slot record used by the EX/MEM and MEM/WB tracking registers.
package ex_id_bypass_unit_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 4;
  localparam int unsigned DEF_CNT_W  = 16;

  localparam logic [DEF_REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DEF_REG_AW-1:0] rd;
    logic                  reg_wr;
    logic                  is_ld;
    logic [DEF_DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/ex_id_bypass_unit_bypass_select.sv
// Priority forwarding mux for one ID operand: EX, then MEM, then WB, then the register file.
module ex_id_bypass_unit_bypass_select
  import ex_id_bypass_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [DATA_W-1:0] id_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wr,
  input  logic              ex_sel_ld,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_wr,
  input  logic              mem_is_ld,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_wr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_c
);

  logic rs_nonzero;

  assign rs_nonzero = (rs != REG_AW'(REG_ZERO));

  // A load in EX has no data yet; the hazard logic covers that case.
  always_comb begin
    fwd_c = id_data;
    if (rs_nonzero) begin
      if (ex_reg_wr && !ex_sel_ld && (ex_rd == rs)) begin
        fwd_c = ex_result;
      end else if (mem_reg_wr && (mem_rd == rs)) begin
        fwd_c = mem_is_ld ? mem_load_data : mem_data;
      end else if (wb_reg_wr && (wb_rd == rs)) begin
        fwd_c = wb_data;
      end
    end
  end

endmodule

// File: rtl/ex_id_bypass_unit.sv
// EX/MEM/WB to ID bypass: tracks in-flight destinations, forwards operands, detects load-use stalls.
module ex_id_bypass_unit
  import ex_id_bypass_unit_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rs_a,
  input  logic [REG_AW-1:0] id_rs_b,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wr,
  input  logic              ex_sel_ld,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_load_data,
  output logic [DATA_W-1:0] fwd_a,
  output logic [DATA_W-1:0] fwd_b,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count
);

  slot_t mem_q;
  slot_t wb_q;
  logic  ex_wr_live;
  logic  hazard_c;
  logic  unused_wb_is_ld;

  assign unused_wb_is_ld = wb_q.is_ld;

  // EX inputs are not yet reset-qualified, so mask them while rst is held.
  assign ex_wr_live = ex_reg_wr && !rst;

  assign hazard_c = id_valid && ex_wr_live && ex_sel_ld
                 && (ex_rd != REG_AW'(REG_ZERO))
                 && ((id_use_a && (ex_rd == id_rs_a)) || (id_use_b && (ex_rd == id_rs_b)));

  assign stall  = hazard_c;
  assign bubble = hazard_c;

  // MEM/WB tracking; WB captures the real load data as the load leaves MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      mem_q.rd     <= ex_rd;
      mem_q.reg_wr <= ex_reg_wr;
      mem_q.is_ld  <= ex_sel_ld;
      mem_q.data   <= ex_result;
      wb_q.rd      <= mem_q.rd;
      wb_q.reg_wr  <= mem_q.reg_wr;
      wb_q.is_ld   <= mem_q.is_ld;
      wb_q.data    <= mem_q.is_ld ? mem_load_data : mem_q.data;
    end
  end

  // Saturating load-use stall event counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (hazard_c && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  ex_id_bypass_unit_bypass_select #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_sel_a (
    .rs            (id_rs_a),
    .id_data       (id_a),
    .ex_rd         (ex_rd),
    .ex_reg_wr     (ex_wr_live),
    .ex_sel_ld     (ex_sel_ld),
    .ex_result     (ex_result),
    .mem_rd        (mem_q.rd),
    .mem_reg_wr    (mem_q.reg_wr),
    .mem_is_ld     (mem_q.is_ld),
    .mem_data      (mem_q.data),
    .mem_load_data (mem_load_data),
    .wb_rd         (wb_q.rd),
    .wb_reg_wr     (wb_q.reg_wr),
    .wb_data       (wb_q.data),
    .fwd_c         (fwd_a)
  );

  ex_id_bypass_unit_bypass_select #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_sel_b (
    .rs            (id_rs_b),
    .id_data       (id_b),
    .ex_rd         (ex_rd),
    .ex_reg_wr     (ex_wr_live),
    .ex_sel_ld     (ex_sel_ld),
    .ex_result     (ex_result),
    .mem_rd        (mem_q.rd),
    .mem_reg_wr    (mem_q.reg_wr),
    .mem_is_ld     (mem_q.is_ld),
    .mem_data      (mem_q.data),
    .mem_load_data (mem_load_data),
    .wb_rd         (wb_q.rd),
    .wb_reg_wr     (wb_q.reg_wr),
    .wb_data       (wb_q.data),
    .fwd_c         (fwd_b)
  );

endmodule

// File: tb/tb_ex_id_bypass_unit.sv
// Directed bench for ex_id_bypass_unit: forwarding priority, load-use stall, reset, saturation.
module tb_ex_id_bypass_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_use_a;
  logic        id_use_b;
  logic [3:0]  id_rs_a;
  logic [3:0]  id_rs_b;
  logic [31:0] id_a;
  logic [31:0] id_b;
  logic [3:0]  ex_rd;
  logic        ex_reg_wr;
  logic        ex_sel_ld;
  logic [31:0] ex_result;
  logic [31:0] mem_load_data;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        stall;
  logic        bubble;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  ex_id_bypass_unit dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_use_a      (id_use_a),
    .id_use_b      (id_use_b),
    .id_rs_a       (id_rs_a),
    .id_rs_b       (id_rs_b),
    .id_a          (id_a),
    .id_b          (id_b),
    .ex_rd         (ex_rd),
    .ex_reg_wr     (ex_reg_wr),
    .ex_sel_ld     (ex_sel_ld),
    .ex_result     (ex_result),
    .mem_load_data (mem_load_data),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .stall         (stall),
    .bubble        (bubble),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    id_valid = 0; id_use_a = 0; id_use_b = 0;
    id_rs_a = 0; id_rs_b = 0; id_a = 0; id_b = 0;
    ex_rd = 0; ex_reg_wr = 0; ex_sel_ld = 0; ex_result = 0;
    mem_load_data = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    id_a = 32'h11; id_b = 32'h22; id_rs_a = 1; id_rs_b = 1;
    ex_rd = 1; ex_reg_wr = 1; ex_result = 32'hAAAA;
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %0b want 0", bubble); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0000", stall_count); end
    checks++; if (fwd_a !== 32'h11) begin errors++; $display("FAIL reset_fwd_a got %h want 00000011", fwd_a); end
    checks++; if (fwd_b !== 32'h22) begin errors++; $display("FAIL reset_fwd_b got %h want 00000022", fwd_b); end
    @(negedge clk);
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_alu_fwd();
    @(negedge clk);
    idle_inputs();
    ex_rd = 3; ex_reg_wr = 1; ex_result = 32'h10;
    id_valid = 1; id_use_a = 1; id_use_b = 1;
    id_rs_a = 3; id_a = 32'hDEAD_BEEF; id_rs_b = 4; id_b = 32'h44;
    #1;
    checks++; if (fwd_a !== 32'h10) begin errors++; $display("FAIL alu_fwd_a got %h want 00000010", fwd_a); end
    checks++; if (fwd_b !== 32'h44) begin errors++; $display("FAIL alu_fwd_b_nomatch got %h want 00000044", fwd_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b want 0", stall); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_inputs();
    ex_rd = 5; ex_reg_wr = 1; ex_sel_ld = 1; ex_result = 32'h999;
    id_valid = 1; id_use_b = 1; id_rs_b = 5; id_b = 32'hBBBB;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall); end
    checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got %0b want 1", bubble); end
    @(negedge clk);
    ex_reg_wr = 0; ex_sel_ld = 0; ex_rd = 0; ex_result = 0;
    mem_load_data = 32'h1234_5678;
    #1;
    checks++; if (fwd_b !== 32'h1234_5678) begin errors++; $display("FAIL lu_mem_fwd_b got %h want 12345678", fwd_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %0b want 0", stall); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got %0d want 1", stall_count); end
    @(negedge clk);
    mem_load_data = 32'h0;
    #1;
    checks++; if (fwd_b !== 32'h1234_5678) begin errors++; $display("FAIL lu_wb_load_data got %h want 12345678", fwd_b); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    idle_inputs();
    ex_rd = 2; ex_reg_wr = 1; ex_result = 32'hC;
    @(negedge clk);
    ex_result = 32'hB;
    @(negedge clk);
    ex_result = 32'hA;
    id_valid = 1; id_use_a = 1; id_use_b = 1;
    id_rs_a = 2; id_rs_b = 2; id_a = 32'h1; id_b = 32'h2;
    #1;
    checks++; if (fwd_a !== 32'hA) begin errors++; $display("FAIL prio_ex_a got %h want 0000000a", fwd_a); end
    checks++; if (fwd_b !== 32'hA) begin errors++; $display("FAIL prio_ex_b got %h want 0000000a", fwd_b); end
    ex_reg_wr = 0;
    #1;
    checks++; if (fwd_a !== 32'hB) begin errors++; $display("FAIL prio_mem_a got %h want 0000000b", fwd_a); end
    checks++; if (fwd_b !== 32'hB) begin errors++; $display("FAIL prio_mem_b got %h want 0000000b", fwd_b); end
    @(negedge clk);
    id_rs_b = 3;
    #1;
    checks++; if (fwd_a !== 32'hB) begin errors++; $display("FAIL prio_wb_a got %h want 0000000b", fwd_a); end
    checks++; if (fwd_b !== 32'h2) begin errors++; $display("FAIL prio_nomatch_b got %h want 00000002", fwd_b); end
  endtask

  task automatic test_r0_guard();
    @(negedge clk);
    idle_inputs();
    ex_rd = 0; ex_reg_wr = 1; ex_result = 32'hFFFF_FFFF;
    id_valid = 1; id_use_a = 1; id_rs_a = 0; id_a = 32'h0;
    #1;
    checks++; if (fwd_a !== 32'h0) begin errors++; $display("FAIL r0_ex_fwd got %h want 00000000", fwd_a); end
    @(negedge clk);
    ex_reg_wr = 0;
    #1;
    checks++; if (fwd_a !== 32'h0) begin errors++; $display("FAIL r0_mem_fwd got %h want 00000000", fwd_a); end
    ex_reg_wr = 1; ex_sel_ld = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_load_stall got %0b want 0", stall); end
  endtask

  task automatic test_independent();
    @(negedge clk);
    idle_inputs();
    ex_rd = 6; ex_reg_wr = 1; ex_result = 32'h66;
    @(negedge clk);
    ex_rd = 7; ex_result = 32'h77;
    id_valid = 1; id_use_a = 1; id_use_b = 1;
    id_rs_a = 6; id_rs_b = 7; id_a = 32'h5; id_b = 32'h6;
    #1;
    checks++; if (fwd_a !== 32'h66) begin errors++; $display("FAIL indep_a_mem got %h want 00000066", fwd_a); end
    checks++; if (fwd_b !== 32'h77) begin errors++; $display("FAIL indep_b_ex got %h want 00000077", fwd_b); end
  endtask

  task automatic test_id_invalid();
    @(negedge clk);
    idle_inputs();
    ex_rd = 5; ex_reg_wr = 1; ex_sel_ld = 1;
    id_valid = 0; id_use_b = 1; id_rs_b = 5;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL invalid_no_stall got %0b want 0", stall); end
    id_valid = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL valid_stall got %0b want 1", stall); end
    ex_reg_wr = 0; ex_sel_ld = 0;
  endtask

  task automatic test_reset_mid_stall();
    logic [15:0] cnt_before;
    @(negedge clk);
    idle_inputs();
    ex_rd = 9; ex_reg_wr = 1; ex_result = 32'h99;
    @(negedge clk);
    ex_reg_wr = 0;
    @(negedge clk);
    id_valid = 1; id_use_a = 1; id_rs_a = 9; id_a = 32'h1;
    #1;
    checks++; if (fwd_a !== 32'h99) begin errors++; $display("FAIL mid_pre_wb_fwd got %h want 00000099", fwd_a); end
    cnt_before = stall_count;
    ex_rd = 5; ex_reg_wr = 1; ex_sel_ld = 1; id_use_b = 1; id_rs_b = 5;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got %0b want 1", stall); end
    checks++; if (cnt_before === 16'h0) begin errors++; $display("FAIL mid_pre_count got %h want nonzero", cnt_before); end
    #1 rst = 1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %0b want 0", stall); end
    checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL mid_rst_bubble got %0b want 0", bubble); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL mid_rst_count got %h want 0000", stall_count); end
    @(negedge clk);
    rst = 0;
    ex_reg_wr = 0; ex_sel_ld = 0; ex_rd = 0; id_use_b = 0; id_rs_b = 0;
    #1;
    checks++; if (fwd_a !== 32'h1) begin errors++; $display("FAIL mid_post_wb_cleared got %h want 00000001", fwd_a); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL mid_post_count got %h want 0000", stall_count); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    idle_inputs();
    ex_rd = 5; ex_reg_wr = 1; ex_sel_ld = 1;
    id_valid = 1; id_use_a = 1; id_rs_a = 5;
    repeat (65534) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h want fffe", stall_count); end
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", stall_count); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_priority();
    test_r0_guard();
    test_independent();
    test_id_invalid();
    test_reset_mid_stall();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
